// File: rtl/sram_1rw1r_param.sv
// sram_1rw1r_param: parametrised single-clock 1RW + 1R SRAM model.
// Port 0 reads or writes (per-lane mask), port 1 reads only. Port 1 forwards
// a same-cycle port 0 write and reports it on the collision output.
// Read latency is 1 or 2 cycles. With INIT_ZERO=1 the whole array is swept
// to zero after reset before any request is accepted.
// Optional feature macro: SRAM_PARITY_EN (per-lane even parity, parity_err0/1).
module sram_1rw1r_param #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LANE_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned INIT_ZERO  = 1
) (
  input  logic                               clk0,
  input  logic                               rstb0,
  input  logic                               csb0,
  input  logic                               web0,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   wmask0,
  input  logic [ADDR_WIDTH-1:0]              addr0,
  input  logic [DATA_WIDTH-1:0]              din0,
  output logic [DATA_WIDTH-1:0]              dout0,
  output logic                               dvalid0,
  input  logic                               csb1,
  input  logic [ADDR_WIDTH-1:0]              addr1,
  output logic [DATA_WIDTH-1:0]              dout1,
  output logic                               dvalid1,
  output logic                               collision,
  output logic                               init_done
`ifdef SRAM_PARITY_EN
  ,
  output logic                               parity_err0,
  output logic                               parity_err1
`endif
);

  localparam int unsigned NUM_WMASKS = DATA_WIDTH / LANE_WIDTH;
  localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;

  // Reject configurations the datapath cannot represent.
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("sram_1rw1r_param: RD_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % LANE_WIDTH) != 0) begin : g_bad_lanes
    $error("sram_1rw1r_param: DATA_WIDTH must be a multiple of LANE_WIDTH");
  end

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
  logic                    init_we_c;
  logic                    init_done_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wr0_c, rd0_c, rd1_c, coll_c;
  logic [DATA_WIDTH-1:0]   rd1_word_c;

  logic                    v0_q, v1_q, col_q;
  logic [DATA_WIDTH-1:0]   d0_q, d1_q;

  // Requests are honoured only once the array reports ready.
  assign wr0_c  = init_done_q & ~csb0 & ~web0;
  assign rd0_c  = init_done_q & ~csb0 &  web0;
  assign rd1_c  = init_done_q & ~csb1;
  assign coll_c = wr0_c & rd1_c & (addr0 == addr1);

  // Init sweep state and counter.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      state_q     <= (INIT_ZERO != 0) ? ST_INIT : ST_READY;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= (state_q == ST_READY);
    end
  end

  // Sweep one word per cycle, leave INIT after the last address.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    init_we_c  = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we_c  = 1'b1;
        init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        if (init_cnt_q == '1) state_d = ST_READY;
      end
      default: ;
    endcase
  end

  // Port 1 word with same-cycle port 0 write lanes merged in.
  always_comb begin
    rd1_word_c = mem[addr1];
    for (int i = 0; i < int'(NUM_WMASKS); i++) begin
      if (coll_c && wmask0[i]) rd1_word_c[i*LANE_WIDTH +: LANE_WIDTH] = din0[i*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  // Array write: zero sweep during INIT, masked lane write otherwise.
  always_ff @(posedge clk0) begin
    if (init_we_c) begin
      mem[init_cnt_q] <= '0;
    end else if (wr0_c) begin
      for (int i = 0; i < int'(NUM_WMASKS); i++) begin
        if (wmask0[i]) mem[addr0][i*LANE_WIDTH +: LANE_WIDTH] <= din0[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

`ifdef SRAM_PARITY_EN
  logic [NUM_WMASKS-1:0] par_mem [DEPTH];
  logic                  perr0_c, perr1_c, perr0_q, perr1_q;
  logic [NUM_WMASKS-1:0] keep1_c;

  function automatic logic [NUM_WMASKS-1:0] lane_par(input logic [DATA_WIDTH-1:0] w);
    lane_par = '0;
    for (int i = 0; i < int'(NUM_WMASKS); i++) lane_par[i] = ^w[i*LANE_WIDTH +: LANE_WIDTH];
  endfunction

  // Forwarded lanes carry fresh parity, so only the untouched lanes can fail.
  assign keep1_c = coll_c ? ~wmask0 : '1;
  assign perr0_c = |(lane_par(mem[addr0]) ^ par_mem[addr0]);
  assign perr1_c = |((lane_par(mem[addr1]) ^ par_mem[addr1]) & keep1_c);

  // Parity array follows the data array write pattern.
  always_ff @(posedge clk0) begin
    if (init_we_c) begin
      par_mem[init_cnt_q] <= '0;
    end else if (wr0_c) begin
      for (int i = 0; i < int'(NUM_WMASKS); i++) begin
        if (wmask0[i]) par_mem[addr0][i] <= ^din0[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end
`endif

  // First read stage: sample array (or forwarded word), data holds when idle.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      v0_q  <= 1'b0;
      v1_q  <= 1'b0;
      col_q <= 1'b0;
      d0_q  <= '0;
      d1_q  <= '0;
`ifdef SRAM_PARITY_EN
      perr0_q <= 1'b0;
      perr1_q <= 1'b0;
`endif
    end else begin
      v0_q  <= rd0_c;
      v1_q  <= rd1_c;
      col_q <= coll_c;
      if (rd0_c) d0_q <= mem[addr0];
      if (rd1_c) d1_q <= rd1_word_c;
`ifdef SRAM_PARITY_EN
      perr0_q <= rd0_c & perr0_c;
      perr1_q <= rd1_c & perr1_c;
`endif
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  v0_qq, v1_qq, col_qq;
    logic [DATA_WIDTH-1:0] d0_qq, d1_qq;
`ifdef SRAM_PARITY_EN
    logic                  perr0_qq, perr1_qq;
`endif

    // Extra output stage; strobes and collision move with the data.
    always_ff @(posedge clk0 or negedge rstb0) begin
      if (!rstb0) begin
        v0_qq  <= 1'b0;
        v1_qq  <= 1'b0;
        col_qq <= 1'b0;
        d0_qq  <= '0;
        d1_qq  <= '0;
`ifdef SRAM_PARITY_EN
        perr0_qq <= 1'b0;
        perr1_qq <= 1'b0;
`endif
      end else begin
        v0_qq  <= v0_q;
        v1_qq  <= v1_q;
        col_qq <= col_q;
        if (v0_q) d0_qq <= d0_q;
        if (v1_q) d1_qq <= d1_q;
`ifdef SRAM_PARITY_EN
        perr0_qq <= perr0_q;
        perr1_qq <= perr1_q;
`endif
      end
    end

    assign dout0     = d0_qq;
    assign dvalid0   = v0_qq;
    assign dout1     = d1_qq;
    assign dvalid1   = v1_qq;
    assign collision = col_qq;
`ifdef SRAM_PARITY_EN
    assign parity_err0 = perr0_qq;
    assign parity_err1 = perr1_qq;
`endif
  end else begin : g_lat1
    assign dout0     = d0_q;
    assign dvalid0   = v0_q;
    assign dout1     = d1_q;
    assign dvalid1   = v1_q;
    assign collision = col_q;
`ifdef SRAM_PARITY_EN
    assign parity_err0 = perr0_q;
    assign parity_err1 = perr1_q;
`endif
  end

  assign init_done = init_done_q;

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Bench for sram_1rw1r_param: two instances (read latency 1 and 2) share one
// stimulus stream; a transaction-level memory model predicts every output.
module tb_sram_1rw1r_param;

  localparam int DEPTH = 256;

  typedef struct packed {
    logic        v0;
    logic [31:0] d0;
    logic        v1;
    logic [31:0] d1;
    logic        col;
  } resp_t;

  logic        clk0, rstb0, csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [7:0]  addr0, addr1;
  logic [31:0] din0;

  logic [31:0] dout0_a, dout1_a, dout0_b, dout1_b;
  logic        dvalid0_a, dvalid1_a, collision_a, init_done_a;
  logic        dvalid0_b, dvalid1_b, collision_b, init_done_b;
`ifdef SRAM_PARITY_EN
  logic        parity_err0_a, parity_err1_a, parity_err0_b, parity_err1_b;
`endif

  int tests = 0;
  int fails = 0;

  sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LANE_WIDTH(8), .RD_LATENCY(1), .INIT_ZERO(1)) u_dut1 (
    .clk0(clk0), .rstb0(rstb0), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(dout0_a), .dvalid0(dvalid0_a), .csb1(csb1), .addr1(addr1), .dout1(dout1_a), .dvalid1(dvalid1_a),
    .collision(collision_a), .init_done(init_done_a)
`ifdef SRAM_PARITY_EN
    , .parity_err0(parity_err0_a), .parity_err1(parity_err1_a)
`endif
  );

  sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LANE_WIDTH(8), .RD_LATENCY(2), .INIT_ZERO(1)) u_dut2 (
    .clk0(clk0), .rstb0(rstb0), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(dout0_b), .dvalid0(dvalid0_b), .csb1(csb1), .addr1(addr1), .dout1(dout1_b), .dvalid1(dvalid1_b),
    .collision(collision_b), .init_done(init_done_b)
`ifdef SRAM_PARITY_EN
    , .parity_err0(parity_err0_b), .parity_err1(parity_err1_b)
`endif
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mdl_mem [DEPTH];
  int          rel_edges = 0;
  logic        exp_init = 1'b0;
  resp_t       prev_r = '0;
  resp_t       exp1 = '0;
  resp_t       exp2 = '0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) if (m[i]) res[i*8 +: 8] = nw[i*8 +: 8];
    return res;
  endfunction

  function automatic resp_t deliver(input resp_t held, input resp_t r);
    resp_t n;
    n     = held;
    n.v0  = r.v0;
    n.v1  = r.v1;
    n.col = r.col;
    if (r.v0) n.d0 = r.d0;
    if (r.v1) n.d1 = r.d1;
    return n;
  endfunction

  // Responses are produced at the request edge and shown L-1 edges later.
  always @(posedge clk0 or negedge rstb0) begin
    resp_t r;
    if (!rstb0) begin
      rel_edges = 0;
      exp_init  = 1'b0;
      prev_r    = '0;
      exp1      = '0;
      exp2      = '0;
      foreach (mdl_mem[i]) mdl_mem[i] = '0;
    end else begin
      r = '0;
      if (exp_init) begin
        if (!csb0 && web0) begin
          r.v0 = 1'b1;
          r.d0 = mdl_mem[addr0];
        end
        if (!csb1) begin
          r.v1 = 1'b1;
          r.d1 = mdl_mem[addr1];
          if (!csb0 && !web0 && addr0 == addr1) begin
            r.col = 1'b1;
            r.d1  = merge(mdl_mem[addr1], din0, wmask0);
          end
        end
        if (!csb0 && !web0) mdl_mem[addr0] = merge(mdl_mem[addr0], din0, wmask0);
      end
      exp1   = deliver(exp1, r);
      exp2   = deliver(exp2, prev_r);
      prev_r = r;
      rel_edges++;
      exp_init = (rel_edges >= DEPTH + 1);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk0) begin
    chk("cmp_init_done_l1", 32'(init_done_a), 32'(exp_init));
    chk("cmp_init_done_l2", 32'(init_done_b), 32'(exp_init));
    chk("cmp_dvalid0_l1",   32'(dvalid0_a),   32'(exp1.v0));
    chk("cmp_dvalid1_l1",   32'(dvalid1_a),   32'(exp1.v1));
    chk("cmp_coll_l1",      32'(collision_a), 32'(exp1.col));
    chk("cmp_dout0_l1",     dout0_a,          exp1.d0);
    chk("cmp_dout1_l1",     dout1_a,          exp1.d1);
    chk("cmp_dvalid0_l2",   32'(dvalid0_b),   32'(exp2.v0));
    chk("cmp_dvalid1_l2",   32'(dvalid1_b),   32'(exp2.v1));
    chk("cmp_coll_l2",      32'(collision_b), 32'(exp2.col));
    chk("cmp_dout0_l2",     dout0_b,          exp2.d0);
    chk("cmp_dout1_l2",     dout1_b,          exp2.d1);
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
    csb1 = 1'b1; addr1 = '0;
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
  endtask

  task automatic rd0(input logic [7:0] a);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a;
  endtask

  task automatic rd1(input logic [7:0] a);
    csb1 = 1'b0; addr1 = a;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_dout0"}, dout0_a | dout0_b, 32'h0);
    chk({nm, "_dout1"}, dout1_a | dout1_b, 32'h0);
    chk({nm, "_flags"}, 32'({dvalid0_a, dvalid1_a, collision_a, init_done_a,
                             dvalid0_b, dvalid1_b, collision_b, init_done_b}), 32'h0);
  endtask

  task automatic wait_init(input string nm);
    repeat (DEPTH) tick();
    chk({nm, "_not_yet"}, 32'(init_done_a), 32'h0);
    tick();
    chk({nm, "_rise_l1"}, 32'(init_done_a), 32'h1);
    chk({nm, "_rise_l2"}, 32'(init_done_b), 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] tmp;
    idle();
    rstb0 = 1'b0;
    repeat (2) @(posedge clk0);
    #2;
    chk_all_zero("reset");
    rstb0 = 1'b1;

    // Init sweep: requests during INIT (including a write) are ignored.
    for (int n = 1; n <= DEPTH; n++) begin
      idle();
      if (n <= 10) begin
        rd1(8'h04);
        if (n == 3) wr(8'h30, 32'hFFFFFFFF, 4'hF);
        else rd0(8'h03);
      end
      tick();
      if (n == 5) chk("init_no_dvalid", 32'({dvalid0_a, dvalid1_a, dvalid0_b, dvalid1_b}), 32'h0);
    end
    chk("init_not_yet", 32'(init_done_a), 32'h0);
    idle();
    tick();
    chk("init_rise_l1", 32'(init_done_a), 32'h1);
    chk("init_rise_l2", 32'(init_done_b), 32'h1);
    rd0(8'h30);
    rd1(8'hC7);
    tick();
    idle();
    chk("init_zero_dv", 32'(dvalid0_a), 32'h1);
    chk("init_zero_rd0", dout0_a, 32'h0);
    chk("init_zero_rd1", dout1_a, 32'h0);
    tick();

    // Masked write, then readback at both latencies.
    wr(8'h10, 32'hDEADBEEF, 4'b1111); tick(); idle();
    rd0(8'h10); tick(); idle();
    chk("wr_full_l1", dout0_a, 32'hDEADBEEF);
    chk("wr_full_l1_dv", 32'(dvalid0_a), 32'h1);
    chk("wr_full_l2_early", 32'(dvalid0_b), 32'h0);
    tick();
    chk("wr_full_l2", dout0_b, 32'hDEADBEEF);
    chk("wr_full_l2_dv", 32'(dvalid0_b), 32'h1);
    chk("wr_full_l1_pulse", 32'(dvalid0_a), 32'h0);
    wr(8'h10, 32'h00AA0000, 4'b0100); tick(); idle();
    chk("wr_no_dvalid", 32'(dvalid0_a), 32'h0);
    rd0(8'h10); tick(); idle();
    chk("wr_lane_l1", dout0_a, 32'hDEAABEEF);
    tick();
    chk("wr_lane_l2", dout0_b, 32'hDEAABEEF);

    // Same-address write/read forwarding and collision.
    wr(8'h05, 32'hAABBCCDD, 4'hF); tick(); idle();
    wr(8'h05, 32'h11223344, 4'b0011); rd1(8'h05); tick(); idle();
    chk("fwd_l1", dout1_a, 32'hAABB3344);
    chk("fwd_coll_l1", 32'(collision_a), 32'h1);
    wr(8'h05, 32'h55667788, 4'hF); rd1(8'h06); tick(); idle();
    chk("fwd_coll_l1_other", 32'(collision_a), 32'h0);
    chk("fwd_l2", dout1_b, 32'hAABB3344);
    chk("fwd_coll_l2", 32'(collision_b), 32'h1);
    rd0(8'h05); rd1(8'h05); tick(); idle();
    chk("coll_l2_drop", 32'(collision_b), 32'h0);
    chk("same_rd_coll", 32'(collision_a), 32'h0);
    chk("same_rd_d0", dout0_a, 32'h55667788);
    chk("same_rd_d1", dout1_a, 32'h55667788);
    wr(8'h07, 32'h12345678, 4'h0); rd1(8'h07); tick(); idle();
    chk("mask0_coll", 32'(collision_a), 32'h1);
    chk("mask0_data", dout1_a, 32'h0);
    tick();

    // Back-to-back port 1 reads at latency 2.
    for (int k = 0; k < 4; k++) begin
      wr(8'(k), 32'h100 + 32'(k), 4'hF); tick();
    end
    idle(); tick();
    for (int k = 0; k < 6; k++) begin
      idle();
      if (k < 4) rd1(8'(k));
      tick();
      if (k >= 1 && k <= 4) begin
        chk("b2b_dv_l2", 32'(dvalid1_b), 32'h1);
        chk("b2b_data_l2", dout1_b, 32'h100 + 32'(k - 1));
      end else begin
        chk("b2b_idle_l2", 32'(dvalid1_b), 32'h0);
      end
    end

    // Randomised traffic on a small address window to provoke collisions.
    for (int n = 0; n < 3000; n++) begin
      idle();
      if ($urandom_range(0, 3) != 0) begin
        csb0   = 1'b0;
        web0   = 1'($urandom);
        addr0  = 8'($urandom_range(0, 15));
        din0   = $urandom;
        wmask0 = 4'($urandom);
      end
      if ($urandom_range(0, 2) != 0) rd1(8'($urandom_range(0, 15)));
      tick();
    end
    idle();
    repeat (3) tick();

`ifdef SRAM_PARITY_EN
    // Corrupt one stored bit of lane 2 and expect a parity error on read.
    wr(8'h20, 32'h01020304, 4'hF); tick(); idle();
    u_dut1.mem[8'h20][17] = ~u_dut1.mem[8'h20][17];
    u_dut2.mem[8'h20][17] = ~u_dut2.mem[8'h20][17];
    tmp = mdl_mem[8'h20];
    tmp[17] = ~tmp[17];
    mdl_mem[8'h20] = tmp;
    rd0(8'h20); tick(); idle();
    chk("par_err_l1", 32'({dvalid0_a, parity_err0_a}), 32'h3);
    rd0(8'h10); tick(); idle();
    chk("par_err_l2", 32'({dvalid0_b, parity_err0_b}), 32'h3);
    chk("par_clean_l1", 32'({dvalid0_a, parity_err0_a}), 32'h2);
    tick();
    chk("par_clean_l2", 32'({dvalid0_b, parity_err0_b}), 32'h2);
`else
    tmp = 32'h0;
`endif

    // Async reset, reset again mid-INIT, sweep restarts and re-zeroes.
    rd0(8'h10); rd1(8'h10); tick(); idle();
    chk("pre_rst_dv", 32'(dvalid0_a & dvalid1_a), 32'h1 | tmp);
    rstb0 = 1'b0;
    #1;
    chk_all_zero("async_rst");
    rstb0 = 1'b1;
    repeat (100) tick();
    rstb0 = 1'b0;
    #1;
    chk_all_zero("mid_init_rst");
    rstb0 = 1'b1;
    wait_init("reinit");
    rd0(8'h10); tick(); idle();
    chk("reinit_zero", dout0_a, 32'h0);
    chk("reinit_zero_dv", 32'(dvalid0_a), 32'h1);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
